// File: rtl/rf_pkg.sv
// Shared encodings for the banked register file: bank selects, move directions
// and the clear/run sequencer states.
package rf_pkg;

   localparam logic BANK_INT = 1'b0;
   localparam logic BANK_FP  = 1'b1;

   localparam logic MV_I2F = 1'b0;
   localparam logic MV_F2I = 1'b1;

   typedef enum logic {INIT, RUN} rf_state_e;

endpackage

// File: rtl/rf_bank.sv
// One DEPTH x WIDTH register bank: two write ports, a combinational peek port
// for move sources, and NUM_RD write-first registered read ports.
module rf_bank #(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned DEPTH  = 32,
   parameter  int unsigned NUM_RD = 2,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wa_en,
   input  logic [AW-1:0]           i_wa_addr,
   input  logic [WIDTH-1:0]        i_wa_data,
   input  logic                    i_wb_en,
   input  logic [AW-1:0]           i_wb_addr,
   input  logic [WIDTH-1:0]        i_wb_data,
   input  logic                    i_rd_en,
   input  logic [NUM_RD*AW-1:0]    i_rd_addr,
   output logic [NUM_RD*WIDTH-1:0] o_rd_data,
   input  logic [AW-1:0]           i_pk_addr,
   output logic [WIDTH-1:0]        o_pk_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd  [NUM_RD];
   logic [WIDTH-1:0] w_fwd [NUM_RD];

   always_ff @(posedge i_clk) begin
      if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
      if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
   end

   assign o_pk_data = r_mem[i_pk_addr];

   // Write-first: a same-cycle write to the read address is forwarded.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         w_fwd[i] = r_mem[i_rd_addr[i*AW +: AW]];
         if (i_wb_en && i_wb_addr == i_rd_addr[i*AW +: AW]) w_fwd[i] = i_wb_data;
         if (i_wa_en && i_wa_addr == i_rd_addr[i*AW +: AW]) w_fwd[i] = i_wa_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_RD; i++) r_rd[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) r_rd[i] <= i_rd_en ? w_fwd[i] : '0;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
      assign o_rd_data[g*WIDTH +: WIDTH] = r_rd[g];
   end

endmodule

// File: rtl/banked_regfile.sv
// Integer + FP register file with post-reset clear sweep, write/move
// arbitration, zero-register masking and per-port bank muxing.
module banked_regfile
   import rf_pkg::*;
#(
   parameter  int unsigned WIDTH    = 32,
   parameter  int unsigned DEPTH    = 32,
   parameter  int unsigned NUM_RD   = 2,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   output logic                    o_ready,
   input  logic                    i_wr_en,
   input  logic                    i_wr_bank,
   input  logic [AW-1:0]           i_wr_addr,
   input  logic [WIDTH-1:0]        i_wr_data,
   input  logic                    i_mv_en,
   input  logic                    i_mv_dir,
   input  logic [AW-1:0]           i_mv_src,
   input  logic [AW-1:0]           i_mv_dst,
   input  logic [NUM_RD-1:0]       i_rd_bank,
   input  logic [NUM_RD*AW-1:0]    i_rd_addr,
   output logic [NUM_RD*WIDTH-1:0] o_rd_data,
   output logic                    o_collision
);

   rf_state_e         r_state, w_state_nxt;
   logic [AW-1:0]     r_clr_cnt;
   logic              r_ready, r_coll;
   logic [NUM_RD-1:0] r_rd_bank;

   logic              w_run, w_wr_ok, w_mv_bank, w_mv_zero, w_hit, w_mv_ok, w_coll;
   logic [WIDTH-1:0]  w_int_pk, w_fp_pk, w_mv_data;
   logic              w_int_wa_en, w_fp_wa_en, w_int_wb_en, w_fp_wb_en;
   logic [AW-1:0]     w_wa_addr;
   logic [WIDTH-1:0]  w_wa_data;
   logic [NUM_RD*WIDTH-1:0] w_int_rd, w_fp_rd;

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == INIT && r_clr_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= INIT;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
         r_coll    <= 1'b0;
         r_rd_bank <= '0;
      end else begin
         r_state   <= w_state_nxt;
         if (r_state == INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
         r_ready   <= (w_state_nxt == RUN);
         r_coll    <= w_coll;
         r_rd_bank <= i_rd_bank;
      end
   end

   // A move into the hardwired zero entry is dropped before any conflict check,
   // so it never raises a collision.
   always_comb begin
      w_run     = (r_state == RUN);
      w_wr_ok   = w_run && i_wr_en &&
                  !(ZERO_REG != 0 && i_wr_bank == BANK_INT && i_wr_addr == '0);
      w_mv_bank = (i_mv_dir == MV_I2F) ? BANK_FP : BANK_INT;
      w_mv_zero = (ZERO_REG != 0) && (w_mv_bank == BANK_INT) && (i_mv_dst == '0);
      w_hit     = i_wr_en && (i_wr_bank == w_mv_bank) && (i_wr_addr == i_mv_dst);
      w_mv_ok   = w_run && i_mv_en && !w_hit && !w_mv_zero;
      w_coll    = w_run && i_mv_en && w_hit && !w_mv_zero;
      w_mv_data = (i_mv_dir == MV_I2F) ? w_int_pk : w_fp_pk;
      w_int_wa_en = !w_run || (w_wr_ok && i_wr_bank == BANK_INT);
      w_fp_wa_en  = !w_run || (w_wr_ok && i_wr_bank == BANK_FP);
      w_wa_addr   = w_run ? i_wr_addr : r_clr_cnt;
      w_wa_data   = w_run ? i_wr_data : '0;
      w_int_wb_en = w_mv_ok && (w_mv_bank == BANK_INT);
      w_fp_wb_en  = w_mv_ok && (w_mv_bank == BANK_FP);
   end

   rf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) u_int_bank (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wa_en   (w_int_wa_en),
      .i_wa_addr (w_wa_addr),
      .i_wa_data (w_wa_data),
      .i_wb_en   (w_int_wb_en),
      .i_wb_addr (i_mv_dst),
      .i_wb_data (w_mv_data),
      .i_rd_en   (w_run),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_int_rd),
      .i_pk_addr (i_mv_src),
      .o_pk_data (w_int_pk)
   );

   rf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) u_fp_bank (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wa_en   (w_fp_wa_en),
      .i_wa_addr (w_wa_addr),
      .i_wa_data (w_wa_data),
      .i_wb_en   (w_fp_wb_en),
      .i_wb_addr (i_mv_dst),
      .i_wb_data (w_mv_data),
      .i_rd_en   (w_run),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_fp_rd),
      .i_pk_addr (i_mv_src),
      .o_pk_data (w_fp_pk)
   );

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_mux
      assign o_rd_data[g*WIDTH +: WIDTH] = r_rd_bank[g] ? w_fp_rd[g*WIDTH +: WIDTH]
                                                        : w_int_rd[g*WIDTH +: WIDTH];
   end

   assign o_ready     = r_ready;
   assign o_collision = r_coll;

endmodule

// File: tb/tb_banked_regfile.sv
// Scoreboard bench: default 32x32/2-port instance with zero register, plus a
// 64-bit/16-entry/3-port instance without zero register.
module tb_banked_regfile;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- instance A: defaults ----------------
   logic        a_rst_n = 1'b0, a_ready, a_coll;
   logic        a_wr_en = 0, a_wr_bank = 0, a_mv_en = 0, a_mv_dir = 0;
   logic [4:0]  a_wr_addr = 0, a_mv_src = 0, a_mv_dst = 0;
   logic [31:0] a_wr_data = 0;
   logic [1:0]  a_rd_bank = 0;
   logic [9:0]  a_rd_addr = 0;
   logic [63:0] a_rd_data;

   banked_regfile u_dut_a (
      .i_clk(clk), .i_rst_n(a_rst_n), .o_ready(a_ready),
      .i_wr_en(a_wr_en), .i_wr_bank(a_wr_bank), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
      .i_mv_en(a_mv_en), .i_mv_dir(a_mv_dir), .i_mv_src(a_mv_src), .i_mv_dst(a_mv_dst),
      .i_rd_bank(a_rd_bank), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
      .o_collision(a_coll)
   );

   // ---------------- instance B: parameter sweep ----------------
   logic         b_rst_n = 1'b0, b_ready, b_coll;
   logic         b_wr_en = 0, b_wr_bank = 0;
   logic [3:0]   b_wr_addr = 0;
   logic [63:0]  b_wr_data = 0;
   logic [2:0]   b_rd_bank = 0;
   logic [11:0]  b_rd_addr = 0;
   logic [191:0] b_rd_data;

   banked_regfile #(.WIDTH(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0)) u_dut_b (
      .i_clk(clk), .i_rst_n(b_rst_n), .o_ready(b_ready),
      .i_wr_en(b_wr_en), .i_wr_bank(b_wr_bank), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
      .i_mv_en(1'b0), .i_mv_dir(1'b0), .i_mv_src(4'd0), .i_mv_dst(4'd0),
      .i_rd_bank(b_rd_bank), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
      .o_collision(b_coll)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model A ----------------
   typedef struct {
      logic        rdy;
      logic        col;
      logic [31:0] d0;
      logic [31:0] d1;
   } exp_a_t;

   exp_a_t      qa[$];
   logic [31:0] mi [32];
   logic [31:0] mf [32];
   int          ma_cnt = 0;
   bit          ma_run = 0;

   task automatic cyc_a(input logic rst, input logic we, input logic wb, input logic [4:0] wa,
                        input logic [31:0] wd, input logic me, input logic md,
                        input logic [4:0] ms, input logic [4:0] mdst, input logic [1:0] rb,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      exp_a_t e;
      logic [31:0] src;
      logic dstb, hit, mz;
      @(negedge clk);
      a_rst_n = rst; a_wr_en = we; a_wr_bank = wb; a_wr_addr = wa; a_wr_data = wd;
      a_mv_en = me; a_mv_dir = md; a_mv_src = ms; a_mv_dst = mdst;
      a_rd_bank = rb; a_rd_addr = {ra1, ra0};
      e.rdy = 0; e.col = 0; e.d0 = 0; e.d1 = 0;
      if (!rst) begin
         ma_cnt = 0; ma_run = 0;
      end else if (!ma_run) begin
         mi[ma_cnt] = 0; mf[ma_cnt] = 0;
         if (ma_cnt == 31) ma_run = 1;
         ma_cnt++;
         e.rdy = ma_run;
      end else begin
         src  = md ? mf[ms] : mi[ms];
         dstb = md ? 1'b0 : 1'b1;
         mz   = (dstb == 1'b0) && (mdst == 0);
         hit  = we && (wb == dstb) && (wa == mdst);
         if (we && !(wb == 1'b0 && wa == 0)) begin
            if (wb) mf[wa] = wd; else mi[wa] = wd;
         end
         if (me && !hit && !mz) begin
            if (dstb) mf[mdst] = src; else mi[mdst] = src;
         end
         e.rdy = 1;
         e.col = me && hit && !mz;
         e.d0  = rb[0] ? mf[ra0] : mi[ra0];
         e.d1  = rb[1] ? mf[ra1] : mi[ra1];
      end
      qa.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_a_t e;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         chk("a_ready", {63'd0, a_ready}, {63'd0, e.rdy});
         chk("a_collision", {63'd0, a_coll}, {63'd0, e.col});
         chk("a_rd0", {32'd0, a_rd_data[31:0]}, {32'd0, e.d0});
         chk("a_rd1", {32'd0, a_rd_data[63:32]}, {32'd0, e.d1});
      end
   end

   // ---------------- reference model B ----------------
   typedef struct {
      logic         rdy;
      logic [191:0] d;
   } exp_b_t;

   exp_b_t      qb[$];
   logic [63:0] mb [2][16];
   int          mb_cnt = 0;
   bit          mb_run = 0;

   task automatic cyc_b(input logic rst, input logic we, input logic wb, input logic [3:0] wa,
                        input logic [63:0] wd, input logic [2:0] rb, input logic [11:0] ra);
      exp_b_t e;
      @(negedge clk);
      b_rst_n = rst; b_wr_en = we; b_wr_bank = wb; b_wr_addr = wa; b_wr_data = wd;
      b_rd_bank = rb; b_rd_addr = ra;
      e.rdy = 0; e.d = '0;
      if (!rst) begin
         mb_cnt = 0; mb_run = 0;
      end else if (!mb_run) begin
         mb[0][mb_cnt] = 0; mb[1][mb_cnt] = 0;
         if (mb_cnt == 15) mb_run = 1;
         mb_cnt++;
         e.rdy = mb_run;
      end else begin
         if (we) mb[wb][wa] = wd;
         e.rdy = 1;
         for (int p = 0; p < 3; p++) e.d[p*64 +: 64] = mb[rb[p]][ra[p*4 +: 4]];
      end
      qb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_b_t e;
      #1;
      if (qb.size() > 0) begin
         e = qb.pop_front();
         chk("b_ready", {63'd0, b_ready}, {63'd0, e.rdy});
         chk("b_collision", {63'd0, b_coll}, 64'd0);
         for (int p = 0; p < 3; p++) chk("b_rd", b_rd_data[p*64 +: 64], e.d[p*64 +: 64]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_a(input logic rst);
      cyc_a(rst, 0, 0, 0, 0, 0, 0, 0, 0, 2'($urandom), 5'($urandom), 5'($urandom));
   endtask

   task automatic junk_a(input logic rst);
      cyc_a(rst, 1, 1'($urandom), 5'($urandom), $urandom, 1, 1'($urandom), 5'($urandom),
            5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
   endtask

   task automatic read_all_a();
      for (int i = 0; i < 32; i++) cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 5'(i), 5'(i));
   endtask

   task automatic seq_a();
      repeat (3) idle_a(0);
      repeat (32) junk_a(1);  // writes and moves during the sweep must be ignored
      read_all_a();
      cyc_a(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 2'b00, 0, 0);
      cyc_a(1, 1, 1, 5, 32'h3F800000, 0, 0, 0, 0, 2'b00, 0, 0);
      cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 5, 5);
      cyc_a(1, 1, 0, 7, 32'h12345678, 0, 0, 0, 0, 2'b00, 7, 0);
      cyc_a(1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 2'b00, 0, 0);
      cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 7);
      cyc_a(1, 1, 0, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 2'b00, 3, 3);
      cyc_a(1, 0, 0, 0, 0, 1, 0, 3, 9, 2'b01, 9, 3);
      cyc_a(1, 0, 0, 0, 0, 1, 1, 9, 0, 2'b00, 0, 3);
      cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0);
      cyc_a(1, 1, 1, 4, 32'h11111111, 1, 0, 3, 4, 2'b01, 4, 4);
      cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4, 4);
      cyc_a(1, 1, 1, 6, 32'h22222222, 1, 0, 5, 8, 2'b11, 6, 8);
      cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 6, 8);
      // Random run with narrow addresses to provoke conflicts and bypasses.
      for (int n = 0; n < 1500; n++) begin
         cyc_a(($urandom_range(0, 299) != 0), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle_a(0);
      repeat (10) junk_a(1);
      repeat (2) idle_a(0);
      repeat (32) junk_a(1);
      read_all_a();
      repeat (2) idle_a(1);
   endtask

   task automatic seq_b();
      logic [11:0] ra;
      repeat (2) cyc_b(0, 0, 0, 0, 0, 0, 0);
      repeat (16) cyc_b(1, 1, 1'($urandom), 4'($urandom), {$urandom, $urandom}, 0, 0);
      cyc_b(1, 1, 0, 0, 64'hCAFEBABE00000001, 3'b000, 12'h000);
      cyc_b(1, 0, 0, 0, 0, 3'b000, 12'h000);
      for (int n = 0; n < 300; n++) begin
         ra = 12'($urandom);
         cyc_b(1, 1'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom},
               3'($urandom), ra);
      end
      cyc_b(1, 0, 0, 0, 0, 3'b010, {4'd9, 4'd0, 4'd5});
      repeat (2) cyc_b(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin mi[i] = 0; mf[i] = 0; end
      for (int i = 0; i < 16; i++) begin mb[0][i] = 0; mb[1][i] = 0; end
      fork
         seq_a();
         seq_b();
      join
      repeat (3) @(negedge clk);
      if (qa.size() != 0 || qb.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d/%0d expected entries left unchecked", qa.size(), qb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
